// File: rtl/filter_video_gen_pkg.sv
// Shared types and encodings for the video test-pattern generator.
// Latency: n/a (package only).
// Backpressure: n/a.
package filter_video_gen_pkg;
  `include "filter_defs.vh"

  // Counter width covers any practical raster (up to 65535 cycles/lines).
  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/filter_video_gen_if.sv
// Control/stream bundle between a pattern-generator client and the generator.
// Latency: n/a (wires only).
// Backpressure: none; the stream is free-running once started.
// Ports: i_en, i_pattern, i_fill_y/u/v (control into generator);
//        o_vs, o_hs, o_de, o_y/u/v, o_busy, o_frame_done (stream out).
interface filter_video_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_en;
  logic [1:0]            i_pattern;
  logic [DATA_WIDTH-1:0] i_fill_y;
  logic [DATA_WIDTH-1:0] i_fill_u;
  logic [DATA_WIDTH-1:0] i_fill_v;
  logic                  o_vs;
  logic                  o_hs;
  logic                  o_de;
  logic [DATA_WIDTH-1:0] o_y;
  logic [DATA_WIDTH-1:0] o_u;
  logic [DATA_WIDTH-1:0] o_v;
  logic                  o_busy;
  logic                  o_frame_done;

  // Client side: drives control, consumes the stream.
  modport master (
    output i_en, i_pattern, i_fill_y, i_fill_u, i_fill_v,
    input  o_vs, o_hs, o_de, o_y, o_u, o_v, o_busy, o_frame_done
  );

  // Generator side.
  modport slave (
    input  i_en, i_pattern, i_fill_y, i_fill_u, i_fill_v,
    output o_vs, o_hs, o_de, o_y, o_u, o_v, o_busy, o_frame_done
  );
endinterface

// File: rtl/filter_defs.vh
// Shared encodings for the video test-pattern generator.
// Latency: n/a (constants only).
// Backpressure: n/a.
`ifndef FILTER_DEFS_VH
`define FILTER_DEFS_VH

// Pattern select encodings (i_pattern).
localparam logic [1:0] PAT_SOLID = 2'd0;
localparam logic [1:0] PAT_HRAMP = 2'd1;
localparam logic [1:0] PAT_VRAMP = 2'd2;
localparam logic [1:0] PAT_CHECK = 2'd3;

// Generator FSM state encodings.
localparam logic [0:0] ST_IDLE = 1'b0;
localparam logic [0:0] ST_RUN  = 1'b1;

`endif

// File: rtl/filter_vgen_timing.sv
// Raster h/v counters with combinational sync/de decode and active-area coordinates.
// Latency: decode is combinational from the counters; counters advance every cycle in run.
// Backpressure: none; counters are held at zero whenever i_run is low.
// Ports: clk, rst, i_run (advance counters) ->
//        o_hs, o_vs, o_de (decoded timing), o_x, o_yl (active column/line), o_last (frame end).
module filter_vgen_timing
  import filter_video_gen_pkg::*;
#(
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_hs,
  output logic o_vs,
  output logic o_de,
  output cnt_t o_x,
  output cnt_t o_yl,
  output logic o_last
);
  localparam cnt_t H_LAST    = cnt_t'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam cnt_t V_LAST    = cnt_t'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam cnt_t H_SYNC_C  = cnt_t'(H_SYNC);
  localparam cnt_t V_SYNC_C  = cnt_t'(V_SYNC);
  localparam cnt_t H_ACT_BEG = cnt_t'(H_SYNC + H_BP);
  localparam cnt_t H_ACT_END = cnt_t'(H_SYNC + H_BP + H_ACTIVE);
  localparam cnt_t V_ACT_BEG = cnt_t'(V_SYNC + V_BP);
  localparam cnt_t V_ACT_END = cnt_t'(V_SYNC + V_BP + V_ACTIVE);

  cnt_t r_h_cnt;
  cnt_t r_v_cnt;
  logic w_h_wrap;

  assign w_h_wrap = (r_h_cnt == H_LAST);

  // Holding the counters at zero outside run means the first run cycle
  // always starts at the top-left of the raster.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!i_run) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + cnt_t'(1);
    end else begin
      r_h_cnt <= r_h_cnt + cnt_t'(1);
    end
  end

  assign o_hs   = (r_h_cnt < H_SYNC_C);
  assign o_vs   = (r_v_cnt < V_SYNC_C);
  assign o_de   = (r_h_cnt >= H_ACT_BEG) && (r_h_cnt < H_ACT_END) &&
                  (r_v_cnt >= V_ACT_BEG) && (r_v_cnt < V_ACT_END);
  // Coordinates are only meaningful while o_de is high.
  assign o_x    = r_h_cnt - H_ACT_BEG;
  assign o_yl   = r_v_cnt - V_ACT_BEG;
  assign o_last = w_h_wrap && (r_v_cnt == V_LAST);
endmodule

// File: rtl/filter_video_gen.sv
// Video test-pattern generator producing a vs/hs/de + YUV stream for the filter pipeline.
// Latency: every output is registered, one cycle behind the raster counters.
// Backpressure: none; runs whole frames while i_en is held, stops only at a frame boundary.
// Ports: clk, rst (async active-high), bus (slave modport: i_en, i_pattern, i_fill_*,
//        o_vs/o_hs/o_de, o_y/o_u/o_v, o_busy, o_frame_done).
module filter_video_gen
  import filter_video_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int H_SYNC     = 44,
  parameter int H_BP       = 148,
  parameter int H_ACTIVE   = 1920,
  parameter int H_FP       = 88,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FP       = 4
) (
  input logic                clk,
  input logic                rst,
  filter_video_gen_if.slave  bus
);
  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic                  w_run;
  logic                  w_frame_start;

  logic [1:0]            r_pat;
  logic [DATA_WIDTH-1:0] r_fill_y;
  logic [DATA_WIDTH-1:0] r_fill_u;
  logic [DATA_WIDTH-1:0] r_fill_v;

  logic                  w_hs;
  logic                  w_vs;
  logic                  w_de;
  logic                  w_last;
  cnt_t                  w_x;
  cnt_t                  w_yl;
  logic [DATA_WIDTH-1:0] w_y;

  logic                  r_vs;
  logic                  r_hs;
  logic                  r_de;
  logic [DATA_WIDTH-1:0] r_y;
  logic [DATA_WIDTH-1:0] r_u;
  logic [DATA_WIDTH-1:0] r_v;
  logic                  r_busy;
  logic                  r_frame_done;

  filter_vgen_timing #(
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP)
  ) u_timing (
    .clk    (clk),
    .rst    (rst),
    .i_run  (w_run),
    .o_hs   (w_hs),
    .o_vs   (w_vs),
    .o_de   (w_de),
    .o_x    (w_x),
    .o_yl   (w_yl),
    .o_last (w_last)
  );

  assign w_run = (r_state == ST_RUN);

  // A frame begins either on leaving IDLE or on wrapping out of the last
  // cycle with i_en still high; both are the moments the shadows reload.
  assign w_frame_start = bus.i_en && (!w_run || w_last);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.i_en) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last && !bus.i_en) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame-stable copies of the control inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat    <= PAT_SOLID;
      r_fill_y <= '0;
      r_fill_u <= '0;
      r_fill_v <= '0;
    end else if (w_frame_start) begin
      r_pat    <= bus.i_pattern;
      r_fill_y <= bus.i_fill_y;
      r_fill_u <= bus.i_fill_u;
      r_fill_v <= bus.i_fill_v;
    end
  end

  // Ramps truncate the coordinate, giving modulo-2^DATA_WIDTH wrap.
  always_comb begin
    w_y = '0;
    case (r_pat)
      PAT_SOLID: w_y = r_fill_y;
      PAT_HRAMP: w_y = DATA_WIDTH'(w_x);
      PAT_VRAMP: w_y = DATA_WIDTH'(w_yl);
      PAT_CHECK: w_y = {DATA_WIDTH{w_x[3] ^ w_yl[3]}};
      default:   w_y = '0;
    endcase
  end

  // The counters idle at zero, which decodes as hs/vs active, so every
  // stream output is gated by run to keep IDLE quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs         <= 1'b0;
      r_hs         <= 1'b0;
      r_de         <= 1'b0;
      r_y          <= '0;
      r_u          <= '0;
      r_v          <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_vs         <= w_run && w_vs;
      r_hs         <= w_run && w_hs;
      r_de         <= w_run && w_de;
      r_y          <= (w_run && w_de) ? w_y      : '0;
      r_u          <= (w_run && w_de) ? r_fill_u : '0;
      r_v          <= (w_run && w_de) ? r_fill_v : '0;
      r_busy       <= w_run;
      r_frame_done <= w_run && w_last;
    end
  end

  assign bus.o_vs         = r_vs;
  assign bus.o_hs         = r_hs;
  assign bus.o_de         = r_de;
  assign bus.o_y          = r_y;
  assign bus.o_u          = r_u;
  assign bus.o_v          = r_v;
  assign bus.o_busy       = r_busy;
  assign bus.o_frame_done = r_frame_done;
endmodule

// File: tb/tb_filter_video_gen.sv
// Directed bench for filter_video_gen: small raster (14x7) plus a 22x19 raster for the checker.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: n/a.
module tb_filter_video_gen;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  filter_video_gen_if #(.DATA_WIDTH(8)) vif ();
  filter_video_gen_if #(.DATA_WIDTH(8)) vif2 ();

  filter_video_gen #(
    .DATA_WIDTH(8), .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  filter_video_gen #(
    .DATA_WIDTH(8), .H_SYNC(2), .H_BP(2), .H_ACTIVE(16), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(16), .V_FP(1)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (vif2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {vs, hs, de, busy, frame_done, y, u, v}
  function automatic logic [31:0] obs1();
    return {3'b0, vif.o_vs, vif.o_hs, vif.o_de, vif.o_busy, vif.o_frame_done,
            vif.o_y, vif.o_u, vif.o_v};
  endfunction

  function automatic logic [31:0] obs2();
    return {3'b0, vif2.o_vs, vif2.o_hs, vif2.o_de, vif2.o_busy, vif2.o_frame_done,
            vif2.o_y, vif2.o_u, vif2.o_v};
  endfunction

  // Walks ncyc output cycles of a 14x7 frame (sync 2/1, back porch 2/1,
  // active 8x4) starting from the first output cycle, checking every cycle.
  // Control inputs may be changed after selected cycles.
  task automatic frame_check(input string tag, input logic [1:0] pat,
                             input logic [7:0] fy, input logic [7:0] fu, input logic [7:0] fv,
                             input int ncyc, input int chg_t, input logic [1:0] chg_pat,
                             input int off_t, input int on_t);
    int vs_n, hs_n, de_n, fd_n;
    vs_n = 0; hs_n = 0; de_n = 0; fd_n = 0;
    for (int t = 0; t < ncyc; t++) begin
      int h, v, x, yl;
      logic e_hs, e_vs, e_de, e_fd;
      logic [7:0] e_y;
      tick();
      h    = t % 14;
      v    = t / 14;
      x    = h - 4;
      yl   = v - 2;
      e_hs = (h < 2);
      e_vs = (v < 1);
      e_de = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
      e_fd = (t == 97);
      case (pat)
        2'd0:    e_y = fy;
        2'd1:    e_y = 8'(x);
        2'd2:    e_y = 8'(yl);
        default: e_y = ((x / 8) % 2 != (yl / 8) % 2) ? 8'hFF : 8'h00;
      endcase
      chk($sformatf("%s t=%0d", tag, t), obs1(),
          {3'b0, e_vs, e_hs, e_de, 1'b1, e_fd,
           e_de ? e_y : 8'h00, e_de ? fu : 8'h00, e_de ? fv : 8'h00});
      vs_n += int'(vif.o_vs);
      hs_n += int'(vif.o_hs);
      de_n += int'(vif.o_de);
      fd_n += int'(vif.o_frame_done);
      if (t == chg_t) vif.i_pattern = chg_pat;
      if (t == off_t) vif.i_en = 1'b0;
      if (t == on_t)  vif.i_en = 1'b1;
    end
    if (ncyc == 98) begin
      chk({tag, " vs_cycles"}, vs_n, 14);
      chk({tag, " hs_cycles"}, hs_n, 14);
      chk({tag, " de_cycles"}, de_n, 32);
      chk({tag, " done_pulses"}, fd_n, 1);
    end
  endtask

  initial begin
    int de2;
    rst = 1'b1;
    vif.i_en = 1'b0;  vif.i_pattern = 2'd0;
    vif.i_fill_y = 8'h80; vif.i_fill_u = 8'h40; vif.i_fill_v = 8'hC0;
    vif2.i_en = 1'b0; vif2.i_pattern = 2'd3;
    vif2.i_fill_y = 8'h00; vif2.i_fill_u = 8'h11; vif2.i_fill_v = 8'h22;

    // Reset and idle state.
    tick(); tick();
    chk("reset outputs", obs1(), 32'h0);
    chk("reset outputs dut2", obs2(), 32'h0);
    rst = 1'b0;
    tick();
    chk("idle outputs", obs1(), 32'h0);

    // Basic solid frame; i_en dropped right after it is sampled.
    vif.i_en = 1'b1;
    tick();
    chk("start edge vs still low", obs1(), 32'h0);
    vif.i_en = 1'b0;
    frame_check("solid", 2'd0, 8'h80, 8'h40, 8'hC0, 98, -1, 2'd0, -1, -1);
    tick();
    chk("after solid idle", obs1(), 32'h0);

    // Horizontal ramp.
    vif.i_pattern = 2'd1; vif.i_en = 1'b1;
    tick();
    vif.i_en = 1'b0;
    frame_check("hramp", 2'd1, 8'h80, 8'h40, 8'hC0, 98, -1, 2'd0, -1, -1);
    tick();
    chk("after hramp idle", obs1(), 32'h0);

    // Vertical ramp, with fill changed mid-frame (must not show).
    vif.i_pattern = 2'd2; vif.i_en = 1'b1;
    tick();
    vif.i_en = 1'b0;
    vif.i_fill_u = 8'h55;
    frame_check("vramp", 2'd2, 8'h80, 8'h40, 8'hC0, 98, -1, 2'd0, -1, -1);
    vif.i_fill_u = 8'h40;
    tick();
    chk("after vramp idle", obs1(), 32'h0);

    // Three back-to-back frames; pattern switched mid-frame 1, i_en
    // glitched low mid-frame 2, dropped for good in frame 3.
    vif.i_pattern = 2'd0; vif.i_en = 1'b1;
    tick();
    frame_check("multi f1", 2'd0, 8'h80, 8'h40, 8'hC0, 98, 50, 2'd1, -1, -1);
    frame_check("multi f2", 2'd1, 8'h80, 8'h40, 8'hC0, 98, -1, 2'd0, 20, 60);
    frame_check("multi f3", 2'd1, 8'h80, 8'h40, 8'hC0, 98, -1, 2'd0, 10, -1);
    tick();
    chk("after multi idle", obs1(), 32'h0);

    // Reset at output cycle 50 of a vertical-ramp frame.
    vif.i_pattern = 2'd2; vif.i_en = 1'b1;
    tick();
    frame_check("pre-reset", 2'd2, 8'h80, 8'h40, 8'hC0, 50, -1, 2'd0, -1, -1);
    rst = 1'b1;
    #1;
    chk("async reset clears", obs1(), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("in reset %0d", i), obs1(), 32'h0);
    end
    rst = 1'b0;
    tick();
    chk("post-reset start edge", obs1(), 32'h0);
    frame_check("post-reset", 2'd2, 8'h80, 8'h40, 8'hC0, 98, -1, 2'd0, 0, -1);
    tick();
    chk("after post-reset idle", obs1(), 32'h0);

    // Checker on a 22x19 raster: line 0 dark then bright, line 8 inverted.
    vif2.i_en = 1'b1;
    tick();
    vif2.i_en = 1'b0;
    de2 = 0;
    for (int t = 0; t < 418; t++) begin
      int h, v;
      tick();
      h = t % 22;
      v = t / 22;
      de2 += int'(vif2.o_de);
      if ((v == 2 || v == 10) && h >= 4 && h < 20) begin
        logic [7:0] e_y;
        if (v == 2) e_y = (h - 4 < 8) ? 8'h00 : 8'hFF;
        else        e_y = (h - 4 < 8) ? 8'hFF : 8'h00;
        chk($sformatf("checker line %0d x=%0d", v - 2, h - 4),
            {22'h0, vif2.o_de, vif2.o_y, 1'b0}, {22'h0, 1'b1, e_y, 1'b0});
      end
      if (t == 417) chk("checker frame_done", {31'h0, vif2.o_frame_done}, 32'h1);
    end
    chk("checker de cycles", de2, 256);
    tick();
    chk("checker idle", obs2(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/filter_video_gen.md
FILTER_VIDEO_GEN -- requirements
Module: filter_video_gen

Interface
REQ-001 The module SHALL have one clock and one reset; the reset is asynchronous and active-high (one clock; reset is asynchronous and active-high).
REQ-002 Parameter DATA_WIDTH, default 8: width of the y/u/v pixel components.
REQ-003 Parameters H_SYNC/H_BP/H_ACTIVE/H_FP, defaults 44/148/1920/88: horizontal timing in clk cycles; H_TOTAL is their sum.
REQ-004 Parameters V_SYNC/V_BP/V_ACTIVE/V_FP, defaults 5/36/1080/4: vertical timing in lines; V_TOTAL is their sum.
REQ-005 Ports, as name, direction, width and meaning:
 clk  in  1  clock
 rst  in  1  asynchronous active-high reset
 i_en  in  1  run request; level-sensitive
 i_pattern  in  2  0 solid, 1 horizontal ramp, 2 vertical ramp, 3 checker
 i_fill_y/i_fill_u/i_fill_v  in  DATA_WIDTH  solid colour; u/v for all patterns
 o_vs/o_hs/o_de  out  1  sync and data-enable, active-high, stream format consumed by the filter pipeline
 o_y/o_u/o_v  out  DATA_WIDTH  pixel components
 o_busy  out  1  state is RUN
 o_frame_done  out  1  one-cycle pulse on the last cycle of each frame

Function
REQ-006 FSM states: IDLE and RUN only.
REQ-007 IDLE->RUN when i_en=1 is sampled; h_cnt and v_cnt are 0 in the first RUN cycle.
REQ-008 In RUN, h_cnt increments every cycle and wraps at H_TOTAL-1; v_cnt increments on the h_cnt wrap and wraps at V_TOTAL-1.
REQ-009 The last cycle of a frame is h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1. In that cycle: if i_en=0, go to IDLE; otherwise start the next frame with no gap.
REQ-010 Deasserting i_en mid-frame SHALL NOT truncate the frame; reasserting it before the frame ends continues seamlessly.
REQ-011 Timing decode:
 - hs=1 for h_cnt<H_SYNC.
 - vs=1 for v_cnt<V_SYNC.
 - de=1 for H_SYNC+H_BP<=h_cnt<H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP<=v_cnt<V_SYNC+V_BP+V_ACTIVE.
REQ-012 All outputs SHALL be registered and lag the counters by exactly 1 cycle. o_vs first rises 2 edges after the edge that samples i_en=1 in IDLE.
REQ-013 x is the active column index and yl is the active line index, both 0-based.
 - Pattern 0: y=i_fill_y.
 - Pattern 1: y=x[DATA_WIDTH-1:0].
 - Pattern 2: y=yl[DATA_WIDTH-1:0].
 - Pattern 3: y=all-ones when x[3]^yl[3]=1, else 0.
 - u=i_fill_u and v=i_fill_v for all patterns.
REQ-014 i_pattern and i_fill_* SHALL be captured into shadow registers at each frame start, including entry to RUN. Changes within a frame have no effect until the next frame.
REQ-015 When o_de=0, o_y, o_u and o_v SHALL be 0.
REQ-016 In IDLE all outputs SHALL be 0.
REQ-017 Ramp counters wrap modulo 2^DATA_WIDTH with no saturation.

Reset
REQ-018 rst=1 SHALL asynchronously force IDLE, zero both counters and shadows, and drive all outputs to 0.
REQ-019 Reset mid-frame SHALL abort the frame with no o_frame_done pulse.
REQ-020 After rst deasserts, a new frame starts from h_cnt=v_cnt=0 only via REQ-007.

Structure
REQ-021 The pattern encodings (PAT_SOLID=0, PAT_HRAMP=1, PAT_VRAMP=2, PAT_CHECK=3) and the FSM state encodings SHALL live in the shared include file filter_defs.vh.
REQ-022 The h/v counters and the sync/de decode SHALL be one sub-module, filter_vgen_timing. Pattern generation and the output registers stay in the top module.

Verification
All scenarios use H_SYNC=2, H_BP=2, H_ACTIVE=8, H_FP=2 (H_TOTAL=14) and V_SYNC=1, V_BP=1, V_ACTIVE=4, V_FP=1 (V_TOTAL=7), giving 98 cycles per frame.
REQ-023 Basic frame: i_en=1 for one frame, pattern 0, fill 0x80/0x40/0xC0.
 - o_vs high for 14 cycles.
 - o_hs high 2 cycles per line.
 - Exactly 32 o_de cycles, all y=0x80, u=0x40, v=0xC0.
 - One o_frame_done pulse, then o_busy=0.
REQ-024 Pattern 1: each active line shows y=0..7. Pattern 2: line k shows y=k for k=0..3.
REQ-025 Pattern 3 with H_ACTIVE=16 and V_ACTIVE=16:
 - Line 0: y=0x00 for x=0..7 and 0xFF for x=8..15.
 - Line 8: inverted.
REQ-026 i_en held high for 3 frames:
 - o_frame_done pulses at 98-cycle spacing with no idle gap.
 - i_pattern changed from 0 to 1 mid-frame 1 takes effect only at the first o_de of frame 2.
REQ-027 rst pulsed at cycle 50 of a frame:
 - All outputs are 0 in the same cycle.
 - No o_frame_done pulse occurs.
 - After rst release with i_en=1, o_vs rises 2 edges later and a full 98-cycle frame follows.
